ldpc_cell_ctrl: RTL and testbench
=================================

// Module: ldpc_cell_ctrl
// PURPOSE
//   Sequencer directly upstream of the per-cell RAM write logic in the LDPC decoder.
//   Generates the one-hot phase vector fsm, the sub-cycle index cycle, wr_en, sin and
//   base_addr for every write cell. Sequence per frame: serial load -> iterative row
//   updates -> output drain. Signals done when the frame is finished.
// PARAMETERS
//   A_WID     8    address width; also the width of base_addr
//   LOAD_LEN  256  soft-input samples accepted per frame in the LOAD phase
//   OUT_LEN   256  cycles spent in the OUT (drain) phase
//   BASE_STEP 3    base_addr increment per row (one word per sub-cycle)
// PORTS
//   clk        in   1      single clock; all logic is rising-edge
//   reset      in   1      synchronous, active-high reset
//   start      in   1      frame start pulse; sampled only in IDLE
//   din_vld    in   1      input sample valid; counted only in LOAD
//   iter_max   in   5      number of decoding iterations; 0 is treated as 1
//   row_num    in   A_WID  rows per iteration; 0 is treated as 1
//   parity_ok  in   1      syndrome-zero flag (used only with LDPC_EARLY_STOP_EN)
//   fsm        out  4      one-hot phase: [0]IDLE [1]LOAD [2]UPD [3]OUT
//   cycle      out  2      UPD sub-cycle 1,2,3; 0 when not issuing
//   wr_en      out  1      update write request (UPD only)
//   sin        out  1      registered din_vld (LOAD only, else 0)
//   base_addr  out  A_WID  row base address = row*BASE_STEP, modulo 2^A_WID
//   iter_cnt   out  5      completed iterations in the current frame
//   busy       out  1      ~fsm[0]
//   done       out  1      one-cycle pulse on the OUT->IDLE transition
// BEHAVIOUR
//   - Reset (sync, with priority over everything): fsm=4'b0001; all other outputs 0;
//     all counters 0. Reset mid-frame aborts the frame and gives no done pulse.
//   - All outputs are registered; there is no combinational input-to-output path.
//   - IDLE: start=1 -> LOAD on the next edge. start is ignored in any other state.
//   - LOAD: sin <= din_vld each cycle. ld_cnt increments on each din_vld. The cycle
//     after the LOAD_LEN-th accepted sample -> UPD, with row=0 and cycle=0.
//   - UPD: per row, cycle steps 1 -> 2 -> 3 with wr_en=1 for all three; then the next
//     row starts immediately (row+1, base_addr += BASE_STEP, cycle=1).
//   - After the last row's cycle 3, one bubble cycle is inserted: wr_en=0, cycle=0.
//     In the bubble: iter_cnt++, row and base_addr clear to 0.
//   - At the bubble, if iter_cnt+1 == max(iter_max,1) -> OUT; else the next iteration begins.
//   - wr_en and cycle are both 0 in every state except UPD issue cycles.
//   - base_addr is stable for all 3 sub-cycles of a row.
//   - OUT: out_cnt counts OUT_LEN cycles. Then done=1 for one cycle and fsm returns to IDLE
//     on that same edge. iter_cnt holds its value until the next start.
//   - Exactly one bit of fsm is set at all times.
// CONFIGURATION
//   LDPC_EARLY_STOP_EN defined: parity_ok is sampled at each iteration bubble; if 1,
//     go to OUT regardless of iter_cnt (iter_cnt still increments).
//   LDPC_EARLY_STOP_EN undefined: parity_ok is ignored; always run max(iter_max,1) iterations.
// STRUCTURE
//   ldpc_ctrl_pkg: one-hot state constants ST_IDLE/ST_LOAD/ST_UPD/ST_OUT (4-bit) and
//     sub-cycle constants CYC_NONE=0, CYC_FIRST=1, CYC_LAST=3.
//   Sub-module ldpc_row_seq: row counter, cycle counter and base_addr accumulator.
//     Inputs: run, row_num. Outputs: cycle, base_addr, row_last, iter_tick.
//   Top level: phase FSM, ld_cnt, out_cnt, iter_cnt.
// TESTING
//   1 reset=1 mid-UPD (row 5, cycle 2) -> next edge: fsm=0001, wr_en=0, cycle=0, base_addr=0, no done.
//   2 start; 256 din_vld with gaps -> sin mirrors din_vld delayed 1; fsm=0100 the cycle after the 256th.
//   3 row_num=2, iter_max=2 -> cycle 1,2,3,1,2,3,0 repeated twice; base_addr 0,0,0,3,3,3,0.
//     Then OUT; iter_cnt=2.
//   4 iter_max=0, row_num=0 -> exactly 1 iteration of 1 row (3 writes), then OUT.
//   5 OUT phase -> done high exactly 1 cycle after 256 OUT cycles; fsm=0001 the same cycle;
//     start during LOAD/UPD/OUT ignored.
//   6 LDPC_EARLY_STOP_EN, iter_max=10, parity_ok=1 at the 3rd bubble -> OUT with iter_cnt=3;
//     without the macro -> iter_cnt=10.

Source files
------------

// File: rtl/ldpc_cell_ctrl_pkg.sv
// ldpc_ctrl_pkg: shared constants for the LDPC cell-write sequencer.
//   phase_t  - one-hot phase vector: [0]IDLE [1]LOAD [2]UPD [3]OUT
//   cyc_t    - UPD sub-cycle index (0 = not issuing, 1..3 = write sub-cycles)
//   iter_limit() - effective iteration count, with 0 mapped to 1
package ldpc_ctrl_pkg;

  typedef logic [3:0] phase_t;
  typedef logic [1:0] cyc_t;
  typedef logic [4:0] iter_t;

  localparam phase_t ST_IDLE = 4'b0001;
  localparam phase_t ST_LOAD = 4'b0010;
  localparam phase_t ST_UPD  = 4'b0100;
  localparam phase_t ST_OUT  = 4'b1000;

  localparam cyc_t CYC_NONE  = 2'd0;
  localparam cyc_t CYC_FIRST = 2'd1;
  localparam cyc_t CYC_LAST  = 2'd3;

  function automatic iter_t iter_limit(input iter_t iter_max);
    return (iter_max == '0) ? iter_t'(1) : iter_max;
  endfunction

endpackage

// File: rtl/ldpc_cell_ctrl_if.sv
// ldpc_cell_ctrl_if: control/status bundle of the LDPC cell-write sequencer.
//   Inputs to the sequencer : start, din_vld, iter_max, row_num, parity_ok
//   Outputs of the sequencer: fsm, cycle, wr_en, sin, base_addr, iter_cnt, busy, done
//   modport master - the frame controller driving the sequencer
//   modport slave  - the sequencer itself
interface ldpc_cell_ctrl_if
  import ldpc_ctrl_pkg::*;
#(
  parameter int unsigned A_WID = 8
) ();

  logic             start;
  logic             din_vld;
  iter_t            iter_max;
  logic [A_WID-1:0] row_num;
  logic             parity_ok;

  phase_t           fsm;
  cyc_t             cycle;
  logic             wr_en;
  logic             sin;
  logic [A_WID-1:0] base_addr;
  iter_t            iter_cnt;
  logic             busy;
  logic             done;

  modport master (
    output start, din_vld, iter_max, row_num, parity_ok,
    input  fsm, cycle, wr_en, sin, base_addr, iter_cnt, busy, done
  );

  modport slave (
    input  start, din_vld, iter_max, row_num, parity_ok,
    output fsm, cycle, wr_en, sin, base_addr, iter_cnt, busy, done
  );

endinterface

// File: rtl/ldpc_cell_ctrl_row_seq.sv
// ldpc_row_seq: row / sub-cycle sequencer for the UPD phase.
//   clk, reset - clock and synchronous active-high reset
//   run        - hold high while the sequencer may advance; low clears all state
//   row_num    - rows per iteration (0 treated as 1)
//   cycle      - sub-cycle 1,2,3 per row; 0 on entry and during the iteration bubble
//   base_addr  - row*BASE_STEP, modulo 2^A_WID; stable across a row's 3 sub-cycles
//   row_last   - current row is the last row of the iteration
//   iter_tick  - high during the bubble cycle that closes an iteration
module ldpc_row_seq
  import ldpc_ctrl_pkg::*;
#(
  parameter int unsigned A_WID     = 8,
  parameter int unsigned BASE_STEP = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [A_WID-1:0] row_num,
  output cyc_t             cycle,
  output logic [A_WID-1:0] base_addr,
  output logic             row_last,
  output logic             iter_tick
);

  localparam logic [A_WID-1:0] Step = A_WID'(BASE_STEP);
  localparam logic [A_WID-1:0] One  = A_WID'(1);

  cyc_t             cyc_q, cyc_d;
  logic [A_WID-1:0] row_q, row_d;
  logic [A_WID-1:0] base_q, base_d;
  logic             tick_q, tick_d;
  logic [A_WID-1:0] last_row;

  assign last_row = (row_num == '0) ? '0 : row_num - One;
  assign row_last = (row_q == last_row);

  always_comb begin
    cyc_d  = cyc_q;
    row_d  = row_q;
    base_d = base_q;
    tick_d = 1'b0;
    if (!run) begin
      cyc_d  = CYC_NONE;
      row_d  = '0;
      base_d = '0;
    end else begin
      case (cyc_q)
        // Entry cycle or bubble: row/base are already at 0, start issuing.
        CYC_NONE: cyc_d = CYC_FIRST;
        CYC_LAST: begin
          if (row_last) begin
            // Close the iteration with one non-issuing bubble cycle.
            cyc_d  = CYC_NONE;
            row_d  = '0;
            base_d = '0;
            tick_d = 1'b1;
          end else begin
            cyc_d  = CYC_FIRST;
            row_d  = row_q + One;
            base_d = base_q + Step;
          end
        end
        default: cyc_d = cyc_q + 2'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q  <= CYC_NONE;
      row_q  <= '0;
      base_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      row_q  <= row_d;
      base_q <= base_d;
      tick_q <= tick_d;
    end
  end

  assign cycle     = cyc_q;
  assign base_addr = base_q;
  assign iter_tick = tick_q;

endmodule

// File: rtl/ldpc_cell_ctrl.sv
// ldpc_cell_ctrl: frame sequencer feeding the per-cell RAM write logic of the LDPC
// decoder. Each frame runs LOAD (LOAD_LEN accepted samples) -> UPD (iterative row
// updates, 3 write sub-cycles per row) -> OUT (OUT_LEN drain cycles), then pulses done.
//   clk, reset - clock and synchronous active-high reset (highest priority)
//   bus        - ldpc_cell_ctrl_if.slave: start, din_vld, iter_max, row_num, parity_ok in;
//                fsm, cycle, wr_en, sin, base_addr, iter_cnt, busy, done out
// Build option: define LDPC_EARLY_STOP_EN to leave UPD early when parity_ok is high at
// an iteration bubble. Without it parity_ok is ignored.
module ldpc_cell_ctrl
  import ldpc_ctrl_pkg::*;
#(
  parameter int unsigned A_WID     = 8,
  parameter int unsigned LOAD_LEN  = 256,
  parameter int unsigned OUT_LEN   = 256,
  parameter int unsigned BASE_STEP = 3
) (
  input  logic            clk,
  input  logic            reset,
  ldpc_cell_ctrl_if.slave bus
);

  localparam int unsigned LdW   = (LOAD_LEN > 1) ? $clog2(LOAD_LEN) : 1;
  localparam int unsigned OutW  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic [LdW-1:0]  LdLast  = LdW'(LOAD_LEN - 1);
  localparam logic [OutW-1:0] OutLast = OutW'(OUT_LEN - 1);

  phase_t          state_q, state_d;
  logic [LdW-1:0]  ld_cnt_q, ld_cnt_d;
  logic [OutW-1:0] out_cnt_q, out_cnt_d;
  iter_t           iter_cnt_q, iter_cnt_d;
  logic            sin_q, sin_d;
  logic            done_q, done_d;

  cyc_t             cycle;
  logic [A_WID-1:0] base_addr;
  logic             row_last;
  logic             iter_tick;
  logic             run;
  logic             last_iter;
  logic             early_stop;
  logic             finish;
  logic [5:0]       iter_next;

  assign iter_next = {1'b0, iter_cnt_q} + 6'd1;
  assign last_iter = (iter_next == {1'b0, iter_limit(bus.iter_max)});

`ifdef LDPC_EARLY_STOP_EN
  assign early_stop = bus.parity_ok;
`else
  logic unused_parity_ok;
  assign unused_parity_ok = bus.parity_ok;
  assign early_stop       = 1'b0;
`endif

  assign finish = iter_tick && (last_iter || early_stop);

  // Row sequencing stops in the final bubble so nothing issues on the way into OUT.
  assign run = (state_q == ST_UPD) && !finish;

  ldpc_row_seq #(
    .A_WID     (A_WID),
    .BASE_STEP (BASE_STEP)
  ) u_row_seq (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .row_num   (bus.row_num),
    .cycle     (cycle),
    .base_addr (base_addr),
    .row_last  (row_last),
    .iter_tick (iter_tick)
  );

  // Row position is tracked inside the sub-module; the top only needs the bubble.
  logic unused_row_last;
  assign unused_row_last = row_last;

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    out_cnt_d  = out_cnt_q;
    iter_cnt_d = iter_cnt_q;
    done_d     = 1'b0;
    sin_d      = (state_q == ST_LOAD) && bus.din_vld;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_LOAD;
          ld_cnt_d   = '0;
          out_cnt_d  = '0;
          iter_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (bus.din_vld) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LdLast) begin
            ld_cnt_d = '0;
            state_d  = ST_UPD;
          end
        end
      end
      ST_UPD: begin
        if (iter_tick) begin
          iter_cnt_d = iter_next[4:0];
          if (finish) begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        out_cnt_d = out_cnt_q + 1'b1;
        if (out_cnt_q == OutLast) begin
          out_cnt_d = '0;
          state_d   = ST_IDLE;
          done_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ld_cnt_q   <= '0;
      out_cnt_q  <= '0;
      iter_cnt_q <= '0;
      sin_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      out_cnt_q  <= out_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      sin_q      <= sin_d;
      done_q     <= done_d;
    end
  end

  assign bus.fsm       = state_q;
  assign bus.cycle     = cycle;
  assign bus.wr_en     = (cycle != CYC_NONE);
  assign bus.sin       = sin_q;
  assign bus.base_addr = base_addr;
  assign bus.iter_cnt  = iter_cnt_q;
  assign bus.busy      = ~state_q[0];
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ldpc_cell_ctrl.sv
// Directed bench for ldpc_cell_ctrl: reset, load with gaps, row/iteration sequencing,
// zero-parameter handling, drain/done timing, mid-frame reset and early stop.
module tb_ldpc_cell_ctrl;
  import ldpc_ctrl_pkg::*;

  localparam int LOAD_N = 256;
  localparam int OUT_N  = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ldpc_cell_ctrl_if #(.A_WID(8)) bus ();

  ldpc_cell_ctrl #(
    .A_WID     (8),
    .LOAD_LEN  (LOAD_N),
    .OUT_LEN   (OUT_N),
    .BASE_STEP (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // {fsm, cycle, wr_en, sin, base_addr, iter_cnt, busy, done}
  function automatic logic [22:0] snap();
    return {bus.fsm, bus.cycle, bus.wr_en, bus.sin, bus.base_addr, bus.iter_cnt,
            bus.busy, bus.done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(output bit ok);
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.din_vld = 1'b1;
    repeat (LOAD_N) tick();
    bus.din_vld = 1'b0;
    ok = (bus.fsm === ST_UPD);
  endtask

  task automatic run_out(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [22:0] exp_v;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.din_vld   = 1'b0;
    bus.iter_max  = 5'd0;
    bus.row_num   = 8'd0;
    bus.parity_ok = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_v = {4'b0001, 2'd0, 1'b0, 1'b0, 8'd0, 5'd0, 1'b0, 1'b0};
    checks++;
    if (snap() !== exp_v) begin
      failures++;
      $display("FAIL reset_state actual=%h required=%h", snap(), exp_v);
    end
  endtask

  // Load with gaps, then row_num=2 / iter_max=2 sequencing into OUT.
  task automatic test_load_upd();
    int          accepted;
    int          cyc;
    bit          v;
    bit          sin_bad;
    bit          fsm_bad;
    logic [1:0]  exp_cyc  [14] = '{1, 2, 3, 1, 2, 3, 0, 1, 2, 3, 1, 2, 3, 0};
    logic [7:0]  exp_base [14] = '{0, 0, 0, 3, 3, 3, 0, 0, 0, 0, 3, 3, 3, 0};
    logic [4:0]  exp_iter [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    logic [17:0] got;
    logic [17:0] want;
    bus.iter_max = 5'd2;
    bus.row_num  = 8'd2;
    bus.start    = 1'b1;
    bus.din_vld  = 1'b0;
    tick();
    checks++;
    if (bus.fsm !== ST_LOAD || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL enter_load fsm=%b busy=%b required fsm=0010 busy=1", bus.fsm, bus.busy);
    end
    // start stays high through LOAD and UPD and must be ignored.
    accepted = 0;
    cyc      = 0;
    sin_bad  = 1'b0;
    fsm_bad  = 1'b0;
    while (accepted < LOAD_N && cyc < 2000) begin
      v = (cyc % 3) != 2;
      bus.din_vld = v;
      tick();
      if (bus.sin !== v) sin_bad = 1'b1;
      if (v) accepted++;
      if (accepted < LOAD_N && bus.fsm !== ST_LOAD) fsm_bad = 1'b1;
      cyc++;
    end
    bus.din_vld = 1'b0;
    checks++;
    if (sin_bad) begin
      failures++;
      $display("FAIL load_sin actual=mismatching_cycle required=sin_equals_prev_din_vld");
    end
    checks++;
    if (fsm_bad) begin
      failures++;
      $display("FAIL load_hold actual=left_load_early required=fsm_0010_until_last_sample");
    end
    checks++;
    if (bus.fsm !== ST_UPD || bus.cycle !== 2'd0 || bus.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL enter_upd fsm=%b cycle=%0d wr_en=%b required fsm=0100 cycle=0 wr_en=0",
               bus.fsm, bus.cycle, bus.wr_en);
    end
    for (int i = 0; i < 14; i++) begin
      tick();
      bus.din_vld = 1'b1;  // ignored outside LOAD: sin must stay 0
      got  = {bus.fsm, bus.cycle, bus.wr_en, bus.sin, bus.base_addr};
      want = {ST_UPD, exp_cyc[i], exp_cyc[i] != 2'd0, 1'b0, exp_base[i]};
      checks++;
      if (got !== want || bus.iter_cnt !== exp_iter[i]) begin
        failures++;
        $display("FAIL upd_step%0d actual=%h iter=%0d required=%h iter=%0d",
                 i, got, bus.iter_cnt, want, exp_iter[i]);
      end
    end
    bus.din_vld = 1'b0;
    tick();
    checks++;
    if (bus.fsm !== ST_OUT || bus.iter_cnt !== 5'd2 || bus.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL enter_out fsm=%b iter=%0d wr_en=%b required fsm=1000 iter=2 wr_en=0",
               bus.fsm, bus.iter_cnt, bus.wr_en);
    end
  endtask

  // Continues from the first OUT cycle of the previous test.
  task automatic test_out();
    bit bad;
    bad = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < OUT_N - 1; i++) begin
      tick();
      if (bus.fsm !== ST_OUT || bus.done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL out_hold actual=left_out_or_done_early required=256_out_cycles");
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.fsm !== ST_IDLE || bus.done !== 1'b1 || bus.iter_cnt !== 5'd2) begin
      failures++;
      $display("FAIL done_pulse fsm=%b done=%b iter=%0d required fsm=0001 done=1 iter=2",
               bus.fsm, bus.done, bus.iter_cnt);
    end
    tick();
    checks++;
    if (bus.fsm !== ST_IDLE || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle fsm=%b done=%b busy=%b required fsm=0001 done=0 busy=0",
               bus.fsm, bus.done, bus.busy);
    end
  endtask

  task automatic test_zero_params();
    bit         ok;
    int         n;
    logic [1:0] exp_cyc [4] = '{1, 2, 3, 0};
    bus.iter_max = 5'd0;
    bus.row_num  = 8'd0;
    run_load(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL zero_load fsm=%b required=0100", bus.fsm);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.fsm !== ST_UPD || bus.cycle !== exp_cyc[i] ||
          bus.wr_en !== (exp_cyc[i] != 2'd0) || bus.base_addr !== 8'd0) begin
        failures++;
        $display("FAIL zero_step%0d fsm=%b cycle=%0d wr_en=%b base=%0d required cycle=%0d",
                 i, bus.fsm, bus.cycle, bus.wr_en, bus.base_addr, exp_cyc[i]);
      end
    end
    tick();
    checks++;
    if (bus.fsm !== ST_OUT || bus.iter_cnt !== 5'd1) begin
      failures++;
      $display("FAIL zero_out fsm=%b iter=%0d required fsm=1000 iter=1", bus.fsm, bus.iter_cnt);
    end
    run_out(n);
    checks++;
    if (n != OUT_N || bus.fsm !== ST_IDLE) begin
      failures++;
      $display("FAIL zero_drain ticks=%0d fsm=%b required ticks=%0d fsm=0001", n, bus.fsm, OUT_N);
    end
  endtask

  task automatic test_reset_mid_upd();
    bit          ok;
    bit          saw_done;
    logic [22:0] exp_v;
    tick();
    bus.iter_max = 5'd1;
    bus.row_num  = 8'd8;
    run_load(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_load fsm=%b required=0100", bus.fsm);
    end
    repeat (17) tick();
    checks++;
    if (bus.cycle !== 2'd2 || bus.base_addr !== 8'd15 || bus.wr_en !== 1'b1) begin
      failures++;
      $display("FAIL mid_position cycle=%0d base=%0d wr_en=%b required cycle=2 base=15 wr_en=1",
               bus.cycle, bus.base_addr, bus.wr_en);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_v = {4'b0001, 2'd0, 1'b0, 1'b0, 8'd0, 5'd0, 1'b0, 1'b0};
    checks++;
    if (snap() !== exp_v) begin
      failures++;
      $display("FAIL mid_reset actual=%h required=%h", snap(), exp_v);
    end
    saw_done = 1'b0;
    repeat (5) begin
      tick();
      if (bus.done !== 1'b0 || bus.fsm !== ST_IDLE) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL mid_no_done actual=done_or_active required=idle_no_done");
    end
  endtask

  task automatic test_early_stop();
    bit         ok;
    int         n;
    int         bubbles;
    logic [1:0] prev;
    logic [4:0] exp_iter;
`ifdef LDPC_EARLY_STOP_EN
    exp_iter = 5'd3;
`else
    exp_iter = 5'd10;
`endif
    bus.iter_max  = 5'd10;
    bus.row_num   = 8'd1;
    bus.parity_ok = 1'b0;
    run_load(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL es_load fsm=%b required=0100", bus.fsm);
    end
    bubbles = 0;
    prev    = 2'd0;
    n       = 0;
    while (bus.fsm === ST_UPD && n < 300) begin
      tick();
      n++;
      bus.parity_ok = 1'b0;
      if (bus.fsm === ST_UPD && bus.cycle === 2'd0 && prev == 2'd3) begin
        bubbles++;
        bus.parity_ok = (bubbles == 3);
      end
      prev = bus.cycle;
    end
    bus.parity_ok = 1'b0;
    checks++;
    if (bus.fsm !== ST_OUT || bus.iter_cnt !== exp_iter) begin
      failures++;
      $display("FAIL early_stop fsm=%b iter=%0d required fsm=1000 iter=%0d",
               bus.fsm, bus.iter_cnt, exp_iter);
    end
    run_out(n);
    checks++;
    if (bus.done !== 1'b1 || bus.iter_cnt !== exp_iter) begin
      failures++;
      $display("FAIL es_drain done=%b iter=%0d required done=1 iter=%0d",
               bus.done, bus.iter_cnt, exp_iter);
    end
  endtask

  initial begin
    test_reset();
    test_load_upd();
    test_out();
    test_zero_params();
    test_reset_mid_upd();
    test_early_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
